gpif_packet_padder: RTL and testbench



---
 rtl/gpif_packet_padder.sv | 206 ++++++++++++++++++++
 tb/tb_gpif_packet_padder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpif_packet_padder.sv
// gpif_packet_padder
//
// Converts a fifo19 VITA packet stream into a raw 16-bit GPIF word stream
// cut into fixed frames of 2^FRAME_LOG2 words. Packet words pass straight
// through with zero latency. After a packet's eof the current frame is
// filled with PAD_WORD up to the frame boundary, so every packet starts on
// a frame boundary. Packets longer than a frame run across frames
// back-to-back, and only their last frame is padded.
//
// Optional build macro: GPIF_PAD_LEN_CHECK_EN
//   When defined, the VITA header length L (in 32-bit words) is latched on
//   sof. err_o is set, and stays set, when a packet's 16-bit word count is
//   not 2*L. When undefined, err_o is tied low and no checker logic is built.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   clear        synchronous clear, with the same effect as reset
//   data_i       {occ, eof, sof, data[15:0]}; occ is ignored
//   src_rdy_i    upstream word valid
//   dst_rdy_o    ready to accept data_i
//   data_o       GPIF word
//   src_rdy_o    data_o valid
//   dst_rdy_i    downstream ready
//   frame_end_o  data_o is the last word of a GPIF frame
//   state        FSM state, for debug (0 IDLE, 1 PKT, 2 PAD)
//   err_o        sticky length-mismatch flag
module gpif_packet_padder #(
  parameter int          FRAME_LOG2 = 8,
  parameter logic [15:0] PAD_WORD   = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [18:0] data_i,
  input  logic        src_rdy_i,
  output logic        dst_rdy_o,
  output logic [15:0] data_o,
  output logic        src_rdy_o,
  input  logic        dst_rdy_i,
  output logic        frame_end_o,
  output logic [1:0]  state,
  output logic        err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_PAD  = 2'd2
  } state_e;

  localparam logic [FRAME_LOG2-1:0] FCNT_LAST = {FRAME_LOG2{1'b1}};
  localparam logic [FRAME_LOG2-1:0] FCNT_ZERO = {FRAME_LOG2{1'b0}};
  localparam logic [FRAME_LOG2-1:0] FCNT_ONE  = {{(FRAME_LOG2-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [FRAME_LOG2-1:0] fcnt_q, fcnt_d;

  logic srst_s;
  logic sof_s;
  logic eof_s;
  logic in_pad_s;
  logic last_s;
  logic xfer_i_s;
  logic xfer_o_s;
  logic occ_unused_s;

  assign srst_s       = reset | clear;
  assign sof_s        = data_i[16];
  assign eof_s        = data_i[17];
  assign occ_unused_s = data_i[18];
  assign in_pad_s     = (state_q == ST_PAD);
  assign last_s       = (fcnt_q == FCNT_LAST);

  // Transfers are derived from the state directly rather than from the muxed
  // handshake outputs, which keeps the next-state logic free of comb loops.
  assign xfer_i_s = src_rdy_i & dst_rdy_i & ~in_pad_s;
  assign xfer_o_s = dst_rdy_i & (in_pad_s | src_rdy_i);

  // During padding the upstream is held off and pad words are offered.
  assign data_o      = in_pad_s ? PAD_WORD : data_i[15:0];
  assign src_rdy_o   = in_pad_s | src_rdy_i;
  assign dst_rdy_o   = dst_rdy_i & ~in_pad_s;
  assign frame_end_o = src_rdy_o & last_s;
  assign state       = state_q;

  // Frame word counter: advances on every word leaving, wraps at frame size.
  always_comb begin
    fcnt_d = fcnt_q;
    if (xfer_o_s) begin
      fcnt_d = fcnt_q + FCNT_ONE;
    end else begin
      fcnt_d = fcnt_q;
    end
  end

  // FSM next-state: an eof that is itself the frame's last word needs no pad.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer_i_s && sof_s) begin
          if (!eof_s) begin
            state_d = ST_PKT;
          end else if (last_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_PAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PKT: begin
        // A sof seen mid-packet is ordinary data; there is no resync.
        if (xfer_i_s && eof_s) begin
          if (last_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_PAD;
          end
        end else begin
          state_d = ST_PKT;
        end
      end
      ST_PAD: begin
        if (xfer_o_s && last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and frame counter registers; a clear abandons any partial frame.
  always_ff @(posedge clk) begin
    if (srst_s) begin
      state_q <= ST_IDLE;
      fcnt_q  <= FCNT_ZERO;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

`ifdef GPIF_PAD_LEN_CHECK_EN
  logic [15:0] len_q, len_d;
  logic [16:0] wcnt_q, wcnt_d;
  logic        err_q, err_d;
  logic [16:0] wcnt_inc_s;
  logic        start_s;
  logic        cont_s;

  assign start_s    = (state_q == ST_IDLE) & xfer_i_s & sof_s;
  assign cont_s     = (state_q == ST_PKT) & xfer_i_s;
  assign wcnt_inc_s = wcnt_q + 17'd1;

  // Length checker: compares the 16-bit word count with twice the header length.
  always_comb begin
    len_d  = len_q;
    wcnt_d = wcnt_q;
    err_d  = err_q;
    if (start_s) begin
      len_d  = data_i[15:0];
      wcnt_d = 17'd1;
      // A one-word packet has an odd count and can never equal 2*L.
      if (eof_s) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else if (cont_s) begin
      wcnt_d = wcnt_inc_s;
      if (eof_s && (wcnt_inc_s != {len_q, 1'b0})) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else begin
      wcnt_d = wcnt_q;
    end
  end

  // Length checker registers; err stays set until reset or clear.
  always_ff @(posedge clk) begin
    if (srst_s) begin
      len_q  <= 16'd0;
      wcnt_q <= 17'd0;
      err_q  <= 1'b0;
    end else begin
      len_q  <= len_d;
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gpif_packet_padder.sv
// Self-checking bench for gpif_packet_padder with 8-word frames and an
// all-ones pad word. A behavioural model tracks the total word count that
// has left the block and the number of pad words still owed. A compare
// process checks every output against that model on each falling edge.
// Directed packets pin the model with literal expectations, and a
// randomized section follows.
module tb_gpif_packet_padder;

  localparam int          FL2  = 3;
  localparam int          FLEN = 1 << FL2;
  localparam logic [15:0] PADW = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [18:0] data_i;
  logic        src_rdy_i;
  logic        dst_rdy_o;
  logic [15:0] data_o;
  logic        src_rdy_o;
  logic        dst_rdy_i;
  logic        frame_end_o;
  logic [1:0]  state;
  logic        err_o;

  gpif_packet_padder #(
    .FRAME_LOG2 (FL2),
    .PAD_WORD   (PADW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .data_i      (data_i),
    .src_rdy_i   (src_rdy_i),
    .dst_rdy_o   (dst_rdy_o),
    .data_o      (data_o),
    .src_rdy_o   (src_rdy_o),
    .dst_rdy_i   (dst_rdy_i),
    .frame_end_o (frame_end_o),
    .state       (state),
    .err_o       (err_o)
  );

  initial forever #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int dst_mode = 0;
  int dst_ph   = 0;
  int first_wait = 0;
  logic [17:0] cap[$];  // {dst_rdy_o, frame_end_o, data_o} per output transfer

  // Behavioural model
  int m_out    = 0;  // words that have left since reset/clear
  int m_pad    = 0;  // pad words still owed
  bit m_in_pkt = 1'b0;
  int m_len    = 0;
  int m_cnt    = 0;
  bit m_err    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_err(input bit e);
`ifdef GPIF_PAD_LEN_CHECK_EN
    return e;
`else
    return 1'b0;
`endif
  endfunction

  // Downstream ready generator
  initial begin
    dst_rdy_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (dst_mode)
        0: dst_rdy_i = 1'b1;
        1: dst_rdy_i = ($urandom_range(0, 3) != 0);
        2: begin
          dst_rdy_i = ((dst_ph % 4) == 0) || ((dst_ph % 4) == 3);
          dst_ph++;
        end
        default: dst_rdy_i = 1'b1;
      endcase
    end
  end

  // Compare process plus model update for the coming edge
  initial begin
    logic        e_src, e_dst, e_fe;
    logic [15:0] e_data;
    logic [1:0]  e_state;
    forever begin
      @(negedge clk);
      if (m_pad > 0) begin
        e_src   = 1'b1;
        e_dst   = 1'b0;
        e_data  = PADW;
        e_fe    = ((m_out % FLEN) == FLEN - 1);
        e_state = 2'd2;
      end else begin
        e_src   = src_rdy_i;
        e_dst   = dst_rdy_i;
        e_data  = data_i[15:0];
        e_fe    = src_rdy_i && ((m_out % FLEN) == FLEN - 1);
        e_state = m_in_pkt ? 2'd1 : 2'd0;
      end
      check("src_rdy_o", {31'd0, src_rdy_o}, {31'd0, e_src});
      check("dst_rdy_o", {31'd0, dst_rdy_o}, {31'd0, e_dst});
      check("data_o", {16'd0, data_o}, {16'd0, e_data});
      check("frame_end_o", {31'd0, frame_end_o}, {31'd0, e_fe});
      check("state", {30'd0, state}, {30'd0, e_state});
      check("err_o", {31'd0, err_o}, {31'd0, exp_err(m_err)});
      if (src_rdy_o && dst_rdy_i) cap.push_back({dst_rdy_o, frame_end_o, data_o});

      if (reset || clear) begin
        m_out = 0; m_pad = 0; m_in_pkt = 1'b0; m_len = 0; m_cnt = 0; m_err = 1'b0;
      end else if (m_pad > 0) begin
        if (dst_rdy_i) begin
          m_out++;
          m_pad--;
        end
      end else if (src_rdy_i && dst_rdy_i) begin
        m_out++;
        if (!m_in_pkt && data_i[16]) begin
          m_in_pkt = 1'b1;
          m_len    = int'(data_i[15:0]);
          m_cnt    = 1;
        end else if (m_in_pkt) begin
          m_cnt++;
        end
        if (m_in_pkt && data_i[17]) begin
          if (m_cnt != 2 * m_len) m_err = 1'b1;
          m_in_pkt = 1'b0;
          m_pad    = (FLEN - (m_out % FLEN)) % FLEN;
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one word and hold it until accepted (bounded).
  task automatic send_word(input logic [18:0] w, output int waited);
    bit acc;
    acc    = 1'b0;
    waited = 0;
    data_i    = w;
    src_rdy_i = 1'b1;
    while (!acc && waited <= 200) begin
      @(negedge clk);
      acc = dst_rdy_o;
      @(posedge clk);
      #1;
      if (!acc) waited++;
    end
    if (!acc) begin
      n_total++;
      $display("FAIL accept_timeout: word %h not accepted within %0d cycles", w, waited);
    end
  endtask

  task automatic send_pkt(input logic [15:0] hdr, input int n, input logic [15:0] base, input bit drop);
    int w;
    for (int k = 0; k < n; k++) begin
      if (k == 0) send_word({1'b0, (n == 1), 1'b1, hdr}, w);
      else        send_word({1'b0, (k == n - 1), 1'b0, base + 16'(k)}, w);
      if (k == 0) first_wait = w;
    end
    if (drop) src_rdy_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset = 1'b1; clear = 1'b0; src_rdy_i = 1'b0; data_i = 19'd0;
    @(posedge clk);
    #1;
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_src_rdy_o", {31'd0, src_rdy_o}, 32'd0);
    check("rst_frame_end_o", {31'd0, frame_end_o}, 32'd0);
    check("rst_err_o", {31'd0, err_o}, 32'd0);
    check("rst_dst_rdy_o", {31'd0, dst_rdy_o}, 32'd1);
    cycles(1);
    reset = 1'b0;
    cycles(1);

    // 4-word packet -> 4 data + 4 pad, frame_end on 8th word
    cap.delete();
    send_pkt(16'h0002, 4, 16'h0009, 1'b1);
    cycles(8);
    check("t1_len", cap.size(), 32'd8);
    if (cap.size() == 8) begin
      check("t1_w0", {14'd0, cap[0]}, {14'd0, 1'b1, 1'b0, 16'h0002});
      check("t1_w1", {14'd0, cap[1]}, {14'd0, 1'b1, 1'b0, 16'h000A});
      check("t1_w3", {14'd0, cap[3]}, {14'd0, 1'b1, 1'b0, 16'h000C});
      check("t1_w4", {14'd0, cap[4]}, {14'd0, 1'b0, 1'b0, 16'hFFFF});
      check("t1_w6", {14'd0, cap[6]}, {14'd0, 1'b0, 1'b0, 16'hFFFF});
      check("t1_w7", {14'd0, cap[7]}, {14'd0, 1'b0, 1'b1, 16'hFFFF});
    end

    // 8-word packet, no pad, then 10-word packet back-to-back
    cap.delete();
    send_pkt(16'h0004, 8, 16'h0300, 1'b0);
    check("t2_len", cap.size(), 32'd8);
    if (cap.size() == 8) begin
      check("t2_w0", {14'd0, cap[0]}, {14'd0, 1'b1, 1'b0, 16'h0004});
      check("t2_w7", {14'd0, cap[7]}, {14'd0, 1'b1, 1'b1, 16'h0307});
    end
    cap.delete();
    send_pkt(16'h0005, 10, 16'h0400, 1'b1);
    check("t2_next_sof_wait", first_wait, 32'd0);
    cycles(10);
    check("t3_len", cap.size(), 32'd16);
    if (cap.size() == 16) begin
      check("t3_w7", {14'd0, cap[7]}, {14'd0, 1'b1, 1'b1, 16'h0407});
      check("t3_w9", {14'd0, cap[9]}, {14'd0, 1'b1, 1'b0, 16'h0409});
      check("t3_w10", {14'd0, cap[10]}, {14'd0, 1'b0, 1'b0, 16'hFFFF});
      check("t3_w15", {14'd0, cap[15]}, {14'd0, 1'b0, 1'b1, 16'hFFFF});
    end

    // Padding under a 1,0,0,1 ready pattern
    cap.delete();
    dst_mode = 2;
    send_pkt(16'h0001, 2, 16'h0500, 1'b1);
    cycles(40);
    dst_mode = 0;
    cycles(2);
    check("t4_len", cap.size(), 32'd8);
    if (cap.size() == 8) begin
      check("t4_w1", {14'd0, cap[1]}, {14'd0, 1'b1, 1'b0, 16'h0501});
      check("t4_w2", {14'd0, cap[2]}, {14'd0, 1'b0, 1'b0, 16'hFFFF});
      check("t4_w7", {14'd0, cap[7]}, {14'd0, 1'b0, 1'b1, 16'hFFFF});
    end

    // clear on the 2nd pad cycle
    send_pkt(16'h0002, 4, 16'h0600, 1'b0);
    data_i = {3'b001, 16'h0002};
    src_rdy_i = 1'b1;
    cycles(1);
    check("t5_in_pad", {30'd0, state}, 32'd2);
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    check("t5_state", {30'd0, state}, 32'd0);
    check("t5_src_rdy_o", {31'd0, src_rdy_o}, 32'd1);
    check("t5_data_o", {16'd0, data_o}, 32'h0002);
    cap.delete();
    send_pkt(16'h0002, 4, 16'h0700, 1'b1);
    check("t5_first_wait", first_wait, 32'd0);
    cycles(8);
    check("t5_len", cap.size(), 32'd8);
    if (cap.size() == 8) begin
      check("t5_w3", {14'd0, cap[3]}, {14'd0, 1'b1, 1'b0, 16'h0703});
      check("t5_w7", {14'd0, cap[7]}, {14'd0, 1'b0, 1'b1, 16'hFFFF});
    end

    // length check: header 3 with 4 words
    check("t6_err_before", {31'd0, err_o}, 32'd0);
    send_pkt(16'h0003, 4, 16'h0800, 1'b1);
    check("t6_err_set", {31'd0, err_o}, {31'd0, exp_err(1'b1)});
    cycles(6);
    send_pkt(16'h0002, 4, 16'h0900, 1'b1);
    cycles(8);
    check("t6_err_held", {31'd0, err_o}, {31'd0, exp_err(1'b1)});
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    check("t6_err_cleared", {31'd0, err_o}, 32'd0);

    // Randomized traffic
    dst_mode = 1;
    for (int p = 0; p < 60; p++) begin
      int n;
      logic [15:0] hdr;
      n   = $urandom_range(1, 20);
      hdr = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'(n / 2);
      if ($urandom_range(0, 5) == 0) begin
        send_word({1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 16'($urandom)}, w);
        src_rdy_i = 1'b0;
      end
      send_pkt(hdr, n, 16'($urandom), 1'b1);
      cycles($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
      end
    end
    dst_mode = 0;
    src_rdy_i = 1'b0;
    cycles(30);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
